// File: rtl/bias_pkg.sv
// Shared constants and helpers for the bias bank: default widths, saturation
// bounds and a lane-slice accessor for packed accumulator vectors.
package bias_pkg;

  localparam int DEF_DATA_W   = 18;
  localparam int DEF_N_LANES  = 16;
  localparam int DEF_N_GROUPS = 4;

  localparam logic [DEF_DATA_W-1:0] SAT_MAX = {1'b0, {(DEF_DATA_W-1){1'b1}}};
  localparam logic [DEF_DATA_W-1:0] SAT_MIN = {1'b1, {(DEF_DATA_W-1){1'b0}}};

  // Lane i of a default-sized packed vector (lane 0 in the low bits).
  function automatic logic [DEF_DATA_W-1:0] lane_of(
    input logic [DEF_N_LANES*DEF_DATA_W-1:0] vec,
    input int                                idx
  );
    return vec[idx*DEF_DATA_W +: DEF_DATA_W];
  endfunction

endpackage

// File: rtl/bias_sat_lane.sv
// One lane of the bias stage: sign-extend, add the bias, clamp to DATA_W bits
// and flag when clamping happened.
module bias_sat_lane
  import bias_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic [DATA_W-1:0] in_i,
  input  logic [DATA_W-1:0] bias_i,
  output logic [DATA_W-1:0] res_o,
  output logic              sat_o
);

  localparam logic [DATA_W-1:0] LANE_MAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic [DATA_W-1:0] LANE_MIN = {1'b1, {(DATA_W-1){1'b0}}};

  logic [DATA_W:0] sum;

  assign sum = {in_i[DATA_W-1], in_i} + {bias_i[DATA_W-1], bias_i};

  // The two top bits disagree exactly when the true sum left the DATA_W range;
  // the extra top bit is the real sign and picks the clamp direction.
  always_comb begin
    res_o = sum[DATA_W-1:0];
    sat_o = 1'b0;
    if (sum[DATA_W] != sum[DATA_W-1]) begin
      sat_o = 1'b1;
      res_o = sum[DATA_W] ? LANE_MIN : LANE_MAX;
    end
  end

endmodule

// File: rtl/bias_add_bank.sv
// Multi-group runtime-loadable bias bank: adds the active group's biases to each
// incoming accumulator vector, saturates per lane and registers the result.
module bias_add_bank
  import bias_pkg::*;
#(
  parameter int N_adder_tree = DEF_N_LANES,
  parameter int DATA_W       = DEF_DATA_W,
  parameter int N_GROUPS     = DEF_N_GROUPS,
  parameter int GRP_W        = (N_GROUPS > 1) ? $clog2(N_GROUPS) : 1,
  parameter int LANE_W       = (N_adder_tree > 1) ? $clog2(N_adder_tree) : 1
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           ld_en,
  input  logic [GRP_W-1:0]               ld_grp,
  input  logic [LANE_W-1:0]              ld_lane,
  input  logic [DATA_W-1:0]              ld_data,
  input  logic                           grp_clr,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [N_adder_tree*DATA_W-1:0] in_data,
  input  logic                           in_last,
  output logic                           out_valid,
  input  logic                           out_ready,
  output logic [N_adder_tree*DATA_W-1:0] out_data,
  output logic [GRP_W-1:0]               out_grp,
  output logic [N_adder_tree-1:0]        sat_flag
);

  localparam int VEC_W = N_adder_tree * DATA_W;

  logic [DATA_W-1:0]       bias_q [N_GROUPS][N_adder_tree];
  logic [GRP_W-1:0]        grp_q, grp_d;
  logic                    out_valid_q, out_valid_d;
  logic [VEC_W-1:0]        out_data_q, out_data_d;
  logic [GRP_W-1:0]        out_grp_q, out_grp_d;
  logic [N_adder_tree-1:0] sat_q, sat_d;

  logic [VEC_W-1:0]        sum_vec;
  logic [N_adder_tree-1:0] sat_vec;
  logic                    in_xfer;
  logic                    ld_wr;

  // Handshake: a side transfers on a cycle where its valid and ready are both
  // high; valid never waits on ready and, once raised, the payload is held
  // until it transfers. in_ready depends only on out_valid/out_ready, so the
  // single output stage streams one vector per cycle while out_ready stays high.
  assign in_ready = !out_valid_q || out_ready;
  assign in_xfer  = in_valid && in_ready;

  assign ld_wr = ld_en && (int'(ld_grp) < N_GROUPS) && (int'(ld_lane) < N_adder_tree);

  // Register file read is combinational, so a same-edge write is seen only
  // by the following transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int g = 0; g < N_GROUPS; g++) begin
        for (int l = 0; l < N_adder_tree; l++) begin
          bias_q[g][l] <= '0;
        end
      end
    end else if (ld_wr) begin
      bias_q[ld_grp][ld_lane] <= ld_data;
    end
  end

  for (genvar i = 0; i < N_adder_tree; i++) begin : g_lane
    bias_sat_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .in_i   (in_data[i*DATA_W +: DATA_W]),
      .bias_i (bias_q[grp_q][i]),
      .res_o  (sum_vec[i*DATA_W +: DATA_W]),
      .sat_o  (sat_vec[i])
    );
  end

  always_comb begin
    grp_d = grp_q;
    if (grp_clr) begin
      grp_d = '0;
    end else if (in_xfer && in_last) begin
      grp_d = (grp_q == GRP_W'(N_GROUPS - 1)) ? '0 : grp_q + 1'b1;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_grp_d   = out_grp_q;
    sat_d       = sat_q;
    if (in_xfer) begin
      out_valid_d = 1'b1;
      out_data_d  = sum_vec;
      out_grp_d   = grp_q;
      sat_d       = sat_vec;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grp_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_grp_q   <= '0;
      sat_q       <= '0;
    end else begin
      grp_q       <= grp_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_grp_q   <= out_grp_d;
      sat_q       <= sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_grp   = out_grp_q;
  assign sat_flag  = sat_q;

endmodule

// File: tb/tb_bias_add_bank.sv
// Directed bench for bias_add_bank: a reference model pushes expected vectors
// as inputs transfer and a negedge monitor pops them as outputs are consumed.
module tb_bias_add_bank;
  import bias_pkg::*;

  localparam int N    = 16;
  localparam int DW   = 18;
  localparam int NG   = 4;
  localparam int GW   = 2;
  localparam int LW   = 4;
  localparam int VW   = N * DW;
  localparam int EW   = VW + GW + N;
  localparam int SMAX = 2**(DW-1) - 1;
  localparam int SMIN = -(2**(DW-1));

  logic          clk = 1'b0;
  logic          rst_n;
  logic          ld_en;
  logic [GW-1:0] ld_grp;
  logic [LW-1:0] ld_lane;
  logic [DW-1:0] ld_data;
  logic          grp_clr;
  logic          in_valid;
  logic          in_ready;
  logic [VW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [VW-1:0] out_data;
  logic [GW-1:0] out_grp;
  logic [N-1:0]  sat_flag;

  always #5 clk = ~clk;

  bias_add_bank dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ld_en     (ld_en),
    .ld_grp    (ld_grp),
    .ld_lane   (ld_lane),
    .ld_data   (ld_data),
    .grp_clr   (grp_clr),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_grp   (out_grp),
    .sat_flag  (sat_flag)
  );

  int            total = 0;
  int            bad   = 0;
  int            cyc   = 0;
  logic [EW-1:0] exp_q[$];
  logic [DW-1:0] mb [NG][N];
  int            mg;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [EW-1:0] model(input logic [VW-1:0] d);
    logic [VW-1:0] o;
    logic [N-1:0]  s;
    int            t;
    o = '0;
    s = '0;
    for (int i = 0; i < N; i++) begin
      t = $signed(lane_of(d, i)) + $signed(mb[mg][i]);
      if (t > SMAX) begin
        t = SMAX;
        s[i] = 1'b1;
      end else if (t < SMIN) begin
        t = SMIN;
        s[i] = 1'b1;
      end
      o[i*DW +: DW] = DW'(t);
    end
    return {o, GW'(mg), s};
  endfunction

  task automatic load(input int g, input int l, input logic [DW-1:0] v);
    ld_en = 1'b1;
    ld_grp = GW'(g);
    ld_lane = LW'(l);
    ld_data = v;
    @(posedge clk);
    #1;
    mb[g][l] = v;
    ld_en = 1'b0;
  endtask

  // Offers one vector, waits (bounded) for it to transfer, then advances the
  // model's group and applies any bias write that shared the transfer edge.
  task automatic xfer(input logic [VW-1:0] d, input logic last, input logic clr);
    int  n;
    bit  done;
    n = 0;
    done = 0;
    in_data = d;
    in_last = last;
    grp_clr = clr;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        exp_q.push_back(model(d));
        done = 1;
      end else if (++n > 50) begin
        total++;
        bad++;
        $error("FAIL xfer_timeout observed=in_ready_low expected=transfer_within_50");
        done = 1;
      end
      @(posedge clk);
    end
    #1;
    if (clr) mg = 0;
    else if (last) mg = (mg + 1) % NG;
    if (ld_en) begin
      mb[ld_grp][ld_lane] = ld_data;
      ld_en = 1'b0;
    end
    in_valid = 1'b0;
    in_last = 1'b0;
    grp_clr = 1'b0;
  endtask

  always @(negedge clk) begin : mon
    logic [EW-1:0] e;
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL unexpected_output observed=%0h expected=none", out_data);
      end else begin
        e = exp_q.pop_front();
        check("sb_data", out_data, e[EW-1 -: VW]);
        check("sb_grp", VW'(out_grp), VW'(e[N +: GW]));
        check("sb_sat", VW'(sat_flag), VW'(e[N-1:0]));
      end
    end
  end

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    int            x;
    for (int i = 0; i < N; i++) begin
      x = int'($urandom_range(0, 100000)) - 50000;
      v[i*DW +: DW] = DW'(x);
    end
    return v;
  endfunction

  initial begin
    logic [VW-1:0] d;
    logic [VW-1:0] held;
    int            c0;

    rst_n = 1'b0;
    ld_en = 1'b0;
    ld_grp = '0;
    ld_lane = '0;
    ld_data = '0;
    grp_clr = 1'b0;
    in_valid = 1'b0;
    in_data = '0;
    in_last = 1'b0;
    out_ready = 1'b0;
    mg = 0;
    for (int g = 0; g < NG; g++) for (int l = 0; l < N; l++) mb[g][l] = '0;

    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    check("rst_out_valid", VW'(out_valid), VW'(0));
    check("rst_out_data", out_data, '0);
    check("rst_out_grp", VW'(out_grp), VW'(0));
    check("rst_sat_flag", VW'(sat_flag), VW'(0));
    check("rst_in_ready", VW'(in_ready), VW'(1));

    // Basic add with one-cycle latency.
    load(0, 0, DW'(100));
    out_ready = 1'b1;
    d = '0;
    d[0 +: DW] = DW'(50);
    xfer(d, 1'b0, 1'b0);
    check("t1_latency_valid", VW'(out_valid), VW'(1));
    check("t1_lane0", VW'(out_data[0 +: DW]), VW'(150));
    check("t1_grp", VW'(out_grp), VW'(0));
    check("t1_sat", VW'(sat_flag), VW'(0));

    // Distinct biases per group, group advance on every 2nd vector, wrap.
    for (int g = 0; g < NG; g++)
      for (int l = 0; l < N; l++)
        load(g, l, DW'(g * 1000 + l * 37 - 250));
    for (int k = 0; k < 9; k++) begin
      xfer(rand_vec(), (k % 2 == 1) && (k < 8), 1'b0);
      check("grp_seq", VW'(out_grp), VW'((k / 2) % NG));
    end

    // Saturation in both directions.
    load(0, 0, DW'(200));
    load(0, 1, DW'(-200));
    d = '0;
    d[0 +: DW] = DW'(131000);
    d[DW +: DW] = DW'(-131000);
    xfer(d, 1'b0, 1'b0);
    check("sat_pos_val", VW'(out_data[0 +: DW]), VW'(18'h1FFFF));
    check("sat_pos_flag", VW'(sat_flag[0]), VW'(1));
    check("sat_neg_val", VW'(out_data[DW +: DW]), VW'(18'h20000));
    check("sat_neg_flag", VW'(sat_flag[1]), VW'(1));

    // Backpressure: output held, input stalled, then streaming resumes.
    @(posedge clk);
    #1 out_ready = 1'b0;
    xfer(rand_vec(), 1'b0, 1'b0);
    held = out_data;
    fork
      xfer(rand_vec(), 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          check("stall_in_ready", VW'(in_ready), VW'(0));
          check("stall_valid", VW'(out_valid), VW'(1));
          check("stall_data", out_data, held);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    c0 = cyc;
    xfer(rand_vec(), 1'b0, 1'b0);
    check("throughput_cycles", VW'(cyc - c0), VW'(1));

    // Write to the active entry on a transfer edge uses the old bias.
    @(posedge clk);
    #1;
    load(0, 0, DW'(3));
    ld_en = 1'b1;
    ld_grp = '0;
    ld_lane = '0;
    ld_data = DW'(7);
    xfer('0, 1'b0, 1'b0);
    check("collide_old", VW'(out_data[0 +: DW]), VW'(3));
    xfer('0, 1'b0, 1'b0);
    check("collide_new", VW'(out_data[0 +: DW]), VW'(7));

    // grp_clr beats in_last; the transfer still uses the pre-clear group.
    xfer(rand_vec(), 1'b1, 1'b0);
    xfer(rand_vec(), 1'b1, 1'b0);
    xfer(rand_vec(), 1'b1, 1'b1);
    check("clr_pre_grp", VW'(out_grp), VW'(2));
    xfer(rand_vec(), 1'b0, 1'b0);
    check("clr_post_grp", VW'(out_grp), VW'(0));

    // Reset while an output is held discards it and all biases.
    @(posedge clk);
    #1 out_ready = 1'b0;
    xfer(rand_vec(), 1'b0, 1'b0);
    check("pre_rst_valid", VW'(out_valid), VW'(1));
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", VW'(out_valid), VW'(0));
    check("async_rst_data", out_data, '0);
    exp_q.delete();
    mg = 0;
    for (int g = 0; g < NG; g++) for (int l = 0; l < N; l++) mb[g][l] = '0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    d = rand_vec();
    xfer(d, 1'b0, 1'b0);
    check("post_rst_zero_bias", out_data, d);
    check("post_rst_sat", VW'(sat_flag), VW'(0));

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", VW'(exp_q.size()), VW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
